// File: rtl/uart_rx_sampler.sv
// Oversampling timing and data recovery for the UART receiver: line synchroniser,
// per-bit edge counter, frame bit counter and a 3-sample mid-bit majority vote.
module uart_rx_sampler #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      edge_count_enable,
    input  logic                      bit_count_enable,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic [3:0]                bit_count,
    output logic                      sampled_bit,
    output logic                      sample_valid,
    output logic                      bit_done,
    output logic                      data_transmitted_finished_flag
);

    localparam logic [3:0] BIT_MAX   = 4'(DATA_WIDTH + 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);

    logic                      rx_meta;
    logic                      rx_s;
    logic [PRESCALE_WIDTH-1:0] p_q;
    logic [PRESCALE_WIDTH-1:0] mid;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic [1:0]                samples;
    logic                      vote;

    always_comb begin
        mid       = p_q >> 1;
        last_edge = p_q - PRESCALE_WIDTH'(1);
        bit_done  = edge_count_enable && (edge_count == last_edge);
        data_transmitted_finished_flag = bit_count_enable && (bit_count == LAST_DATA);
        // The third vote is the live synchronised sample taken at mid+1.
        vote = (samples[0] & samples[1]) | (samples[0] & rx_s) | (samples[1] & rx_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            p_q          <= PRESCALE_WIDTH'(8);
            edge_count   <= '0;
            bit_count    <= '0;
            samples      <= '0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            rx_meta      <= RX_IN;
            rx_s         <= rx_meta;
            sample_valid <= 1'b0;

            // Prescale is frozen for as long as the edge counter runs.
            if (!edge_count_enable) begin
                p_q <= prescale;
            end

            if (!edge_count_enable || bit_done) begin
                edge_count <= '0;
            end else begin
                edge_count <= edge_count + PRESCALE_WIDTH'(1);
            end

            if (!bit_count_enable) begin
                bit_count <= '0;
            end else if (bit_done && (bit_count != BIT_MAX)) begin
                bit_count <= bit_count + 4'd1;
            end

            // Dropping the enable throws away any partial vote for this bit.
            if (!edge_count_enable) begin
                samples <= '0;
            end else begin
                if (edge_count == mid - PRESCALE_WIDTH'(1)) begin
                    samples[0] <= rx_s;
                end
                if (edge_count == mid) begin
                    samples[1] <= rx_s;
                end
                if (edge_count == mid + PRESCALE_WIDTH'(1)) begin
                    sampled_bit  <= vote;
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scenario bench for uart_rx_sampler: directed timing checks plus a randomized run
// compared cycle by cycle against an arithmetic reference model.
module tb_uart_rx_sampler;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          edge_count_enable;
    logic          bit_count_enable;
    logic [PW-1:0] edge_count;
    logic [3:0]    bit_count;
    logic          sampled_bit;
    logic          sample_valid;
    logic          bit_done;
    logic          data_transmitted_finished_flag;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles since the edge enable rose, latched prescale,
    // completed bit count, recovered bit and a history of synchronised line values.
    int m_k, m_p, m_edge, m_bits;
    bit m_sb, m_sv, m_rxs;
    bit sync_q[$];
    bit hist_q[$];
    bit exp_bd, exp_flag;
    logic [DW-1:0] exp_q[$];

    uart_rx_sampler #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .RX_IN                          (rx_in),
        .prescale                       (prescale),
        .edge_count_enable              (edge_count_enable),
        .bit_count_enable               (bit_count_enable),
        .edge_count                     (edge_count),
        .bit_count                      (bit_count),
        .sampled_bit                    (sampled_bit),
        .sample_valid                   (sample_valid),
        .bit_done                       (bit_done),
        .data_transmitted_finished_flag (data_transmitted_finished_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    // Advance the model across the clock edge that just happened, using the
    // inputs that were applied during the cycle that edge ended.
    task automatic next_cycle();
        int mid, ones;
        bit done;
        @(posedge clk);
        #1;
        if (rst) begin
            m_k = 0; m_p = 8; m_edge = 0; m_bits = 0;
            m_sb = 1'b1; m_sv = 1'b0; m_rxs = 1'b1;
            sync_q = '{1'b1};
            hist_q = '{1'b1, 1'b1, 1'b1};
        end else begin
            mid  = m_p / 2;
            done = edge_count_enable && (m_edge == m_p - 1);
            ones = int'(hist_q[0]) + int'(hist_q[1]) + int'(hist_q[2]);
            m_sv = edge_count_enable && (m_edge == mid + 1);
            if (m_sv) m_sb = (ones >= 2);
            if (!bit_count_enable) m_bits = 0;
            else if (done && m_bits < DW + 1) m_bits = m_bits + 1;
            if (!edge_count_enable) m_p = int'(prescale);
            m_k    = edge_count_enable ? m_k + 1 : 0;
            m_edge = m_k % m_p;
            sync_q.push_back(rx_in);
            m_rxs = sync_q.pop_front();
            hist_q.push_back(m_rxs);
            void'(hist_q.pop_front());
        end
    endtask

    task automatic apply(input bit r, input bit rx, input bit en, input bit ben, input int pre);
        rst               = r;
        rx_in             = rx;
        edge_count_enable = en;
        bit_count_enable  = ben;
        prescale          = PW'(pre);
        exp_bd   = en && (m_edge == m_p - 1);
        exp_flag = ben && (m_bits == DW - 1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1, 0, 1, 1, 8);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i == 0) apply(1, 1, 1, 1, 8);
            else apply(0, 1, 0, 0, 8);
            n_checks++; if (edge_count !== 0) begin n_fail++; $display("FAIL reset_edge_count[%0d]: got %0d expected 0", i, edge_count); end
            n_checks++; if (bit_count !== 0) begin n_fail++; $display("FAIL reset_bit_count[%0d]: got %0d expected 0", i, bit_count); end
            n_checks++; if (sampled_bit !== 1'b1) begin n_fail++; $display("FAIL reset_sampled_bit[%0d]: got %b expected 1", i, sampled_bit); end
            n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sample_valid[%0d]: got %b expected 0", i, sample_valid); end
            n_checks++; if (bit_done !== 1'b0) begin n_fail++; $display("FAIL reset_bit_done[%0d]: got %b expected 0", i, bit_done); end
            n_checks++; if (data_transmitted_finished_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag[%0d]: got %b expected 0", i, data_transmitted_finished_flag); end
        end
    endtask

    task automatic test_const_zero();
        for (int i = 0; i < 3; i++) begin next_cycle(); apply(0, 0, 0, 0, 8); end
        for (int c = 0; c < 32; c++) begin
            next_cycle();
            apply(0, 0, 1, 0, 8);
            n_checks++; if (edge_count !== PW'(c % 8)) begin n_fail++; $display("FAIL zero_edge_count[%0d]: got %0d expected %0d", c, edge_count, c % 8); end
            n_checks++; if (bit_done !== (c % 8 == 7)) begin n_fail++; $display("FAIL zero_bit_done[%0d]: got %b expected %b", c, bit_done, c % 8 == 7); end
            n_checks++; if (sample_valid !== (c % 8 == 6)) begin n_fail++; $display("FAIL zero_sample_valid[%0d]: got %b expected %b", c, sample_valid, c % 8 == 6); end
            if (c % 8 == 6) begin
                n_checks++; if (sampled_bit !== 1'b0) begin n_fail++; $display("FAIL zero_sampled_bit[%0d]: got %b expected 0", c, sampled_bit); end
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] pats [8];
        bit rx, want;
        pats[0] = 3'b101; pats[1] = 3'b110; pats[2] = 3'b100;
        for (int i = 3; i < 8; i++) pats[i] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) begin next_cycle(); apply(0, 1, 0, 0, 8); end
        for (int p = 0; p < 8; p++) begin
            want = (int'(pats[p][0]) + int'(pats[p][1]) + int'(pats[p][2])) >= 2;
            for (int e = 0; e < 8; e++) begin
                next_cycle();
                // rx_s at edges 3..5 reflects the line driven two cycles earlier.
                rx = (e >= 1 && e <= 3) ? pats[p][e-1] : 1'($urandom_range(0, 1));
                apply(0, rx, 1, 0, 8);
                if (e == 6) begin
                    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_valid[%0d]: got %b expected 1", p, sample_valid); end
                    n_checks++; if (sampled_bit !== want) begin n_fail++; $display("FAIL glitch_vote[%0d] pattern %b: got %b expected %b", p, pats[p], sampled_bit, want); end
                end
            end
        end
        next_cycle(); apply(0, 1, 0, 0, 8);
    endtask

    task automatic test_frame();
        logic [10:0] frame;
        logic [DW-1:0] got;
        frame = {3'($urandom_range(0, 7)), 8'hA5};
        exp_q.push_back(8'hA5);
        got = '0;
        for (int i = 0; i < 4; i++) begin next_cycle(); apply(0, 1, 0, 0, 16); end
        for (int b = 0; b < 11; b++) begin
            for (int e = 0; e < 16; e++) begin
                next_cycle();
                apply(0, frame[b], 1, 1, 16);
                n_checks++; if (bit_count !== 4'((b < 9) ? b : 9)) begin n_fail++; $display("FAIL frame_bit_count[%0d.%0d]: got %0d expected %0d", b, e, bit_count, (b < 9) ? b : 9); end
                n_checks++; if (data_transmitted_finished_flag !== (b == 7)) begin n_fail++; $display("FAIL frame_flag[%0d.%0d]: got %b expected %b", b, e, data_transmitted_finished_flag, b == 7); end
                n_checks++; if (sample_valid !== (e == 10)) begin n_fail++; $display("FAIL frame_valid[%0d.%0d]: got %b expected %b", b, e, sample_valid, e == 10); end
                if (e == 10) begin
                    if (b < DW) got[b] = sampled_bit;
                    n_checks++; if (sampled_bit !== frame[b]) begin n_fail++; $display("FAIL frame_bit[%0d]: got %b expected %b", b, sampled_bit, frame[b]); end
                end
            end
        end
        n_checks++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL frame_byte: got %h expected %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        next_cycle(); apply(0, 1, 1, 1, 16);
        n_checks++; if (bit_count !== 4'd9) begin n_fail++; $display("FAIL frame_saturate: got %0d expected 9", bit_count); end
        next_cycle(); apply(0, 1, 0, 0, 16);
        next_cycle(); apply(0, 1, 0, 0, 16);
        n_checks++; if (bit_count !== 4'd0) begin n_fail++; $display("FAIL frame_clear: got %0d expected 0", bit_count); end
    endtask

    task automatic test_abort();
        int drops [3] = '{4, 8, 9};
        bit held;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 2; i++) begin next_cycle(); apply(0, 1, 0, 0, 16); end
            held = m_sb;
            for (int e = 0; e < drops[d]; e++) begin next_cycle(); apply(0, ~held, 1, 0, 16); end
            next_cycle(); apply(0, ~held, 0, 0, 16);
            n_checks++; if (edge_count !== PW'(drops[d])) begin n_fail++; $display("FAIL abort_edge_at_drop[%0d]: got %0d expected %0d", d, edge_count, drops[d]); end
            for (int c = 0; c < 14; c++) begin
                next_cycle(); apply(0, ~held, 0, 0, 16);
                if (c == 0) begin
                    n_checks++; if (edge_count !== 0) begin n_fail++; $display("FAIL abort_edge_clear[%0d]: got %0d expected 0", d, edge_count); end
                end
                n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid[%0d.%0d]: got %b expected 0", d, c, sample_valid); end
                n_checks++; if (sampled_bit !== held) begin n_fail++; $display("FAIL abort_hold[%0d.%0d]: got %b expected %b", d, c, sampled_bit, held); end
            end
        end
        for (int c = 0; c < 32; c++) begin
            next_cycle();
            apply(0, 1, 1, (c != 31), 16);
            if (c == 31) begin
                n_checks++; if (bit_done !== 1'b1) begin n_fail++; $display("FAIL abort_bit_done: got %b expected 1", bit_done); end
                n_checks++; if (bit_count !== 4'd1) begin n_fail++; $display("FAIL abort_bit_count_before: got %0d expected 1", bit_count); end
            end
        end
        next_cycle(); apply(0, 1, 0, 0, 16);
        n_checks++; if (bit_count !== 4'd0) begin n_fail++; $display("FAIL abort_clear_wins: got %0d expected 0", bit_count); end
    endtask

    task automatic test_prescale_change();
        for (int i = 0; i < 2; i++) begin next_cycle(); apply(0, 1, 0, 0, 8); end
        for (int c = 0; c < 24; c++) begin
            next_cycle();
            apply(0, 1'($urandom_range(0, 1)), 1, 0, (c < 3) ? 8 : 32);
            n_checks++; if (bit_done !== (c % 8 == 7)) begin n_fail++; $display("FAIL pchg_old_bit_done[%0d]: got %b expected %b", c, bit_done, c % 8 == 7); end
        end
        next_cycle(); apply(0, 1, 0, 0, 32);
        for (int c = 0; c < 64; c++) begin
            next_cycle();
            apply(0, 1'($urandom_range(0, 1)), 1, 0, 32);
            n_checks++; if (edge_count !== PW'(c % 32)) begin n_fail++; $display("FAIL pchg_edge[%0d]: got %0d expected %0d", c, edge_count, c % 32); end
            n_checks++; if (bit_done !== (c % 32 == 31)) begin n_fail++; $display("FAIL pchg_bit_done[%0d]: got %b expected %b", c, bit_done, c % 32 == 31); end
            n_checks++; if (sample_valid !== (c % 32 == 18)) begin n_fail++; $display("FAIL pchg_valid[%0d]: got %b expected %b", c, sample_valid, c % 32 == 18); end
        end
        next_cycle(); apply(0, 1, 0, 0, 8);
    endtask

    task automatic test_random();
        bit en = 0, ben = 0, rx = 1, r;
        int pre = 16;
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 79) == 0) ben = ~ben;
            if ($urandom_range(0, 5) == 0) rx = ~rx;
            if ($urandom_range(0, 9) == 0) pre = 8 << $urandom_range(0, 2);
            apply(r, rx, en, ben, pre);
            n_checks++; if (edge_count !== PW'(m_edge)) begin n_fail++; $display("FAIL rand_edge[%0d]: got %0d expected %0d", c, edge_count, m_edge); end
            n_checks++; if (bit_count !== 4'(m_bits)) begin n_fail++; $display("FAIL rand_bit_count[%0d]: got %0d expected %0d", c, bit_count, m_bits); end
            n_checks++; if (sampled_bit !== m_sb) begin n_fail++; $display("FAIL rand_sampled_bit[%0d]: got %b expected %b", c, sampled_bit, m_sb); end
            n_checks++; if (sample_valid !== m_sv) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, sample_valid, m_sv); end
            n_checks++; if (bit_done !== exp_bd) begin n_fail++; $display("FAIL rand_bit_done[%0d]: got %b expected %b", c, bit_done, exp_bd); end
            n_checks++; if (data_transmitted_finished_flag !== exp_flag) begin n_fail++; $display("FAIL rand_flag[%0d]: got %b expected %b", c, data_transmitted_finished_flag, exp_flag); end
        end
    endtask

    initial begin
        m_k = 0; m_p = 8; m_edge = 0; m_bits = 0;
        m_sb = 1'b1; m_sv = 1'b0; m_rxs = 1'b1;
        sync_q = '{1'b1};
        hist_q = '{1'b1, 1'b1, 1'b1};
        test_reset();
        test_const_zero();
        test_glitch();
        test_frame();
        test_abort();
        test_prescale_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling timing and data-recovery stage of the UART receiver, sitting between the serial line and the RX control FSM. It synchronises the raw line, runs the per-bit edge counter and the frame bit counter under FSM enables, and takes a 3-sample majority vote at mid-bit. It returns the recovered bit together with the bit-boundary and last-data-bit indications that drive FSM state changes.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal 5..14.
- PRESCALE_WIDTH, 6: width of the prescale/edge counter.

- clk  in  1  receiver clock (prescale × baud).
- rst  in  1  reset, synchronous, active-high. The design has one clock; reset is synchronous and active-high.
- RX_IN  in  1  raw serial line, asynchronous, idle high.
- prescale  in  PRESCALE_WIDTH  oversampling factor; legal values 8, 16, 32.
- edge_count_enable  in  1  from FSM; run the edge counter and sampler.
- bit_count_enable  in  1  from FSM; run the bit counter.
- edge_count  out  PRESCALE_WIDTH  current oversample edge within the bit.
- bit_count  out  4  bits completed since bit_count_enable rose.
- sampled_bit  out  1  majority-voted bit value, held between updates.
- sample_valid  out  1  one-cycle strobe: sampled_bit updated.
- bit_done  out  1  bit-boundary strobe; the FSM uses it as state_change_enable.
- data_transmitted_finished_flag  out  1  high while the last data bit is being received.

## Operation
- **Synchroniser:** RX_IN passes through 2 flops, both reset to 1. All logic uses the synchronised value rx_s.
- **Prescale latch:**
  - An internal register p_q loads prescale on every cycle where edge_count_enable=0. It reset-loads 8.
  - While edge_count_enable=1, p_q holds; prescale changes are ignored until the enable next goes low.
  - mid = p_q>>1.
- **Edge counter:**
  - edge_count_enable=0: edge_count clears to 0 next cycle.
  - edge_count_enable=1: edge_count increments each cycle and wraps from p_q-1 to 0.
- **bit_done:** combinational, = edge_count_enable & (edge_count == p_q-1).
- **Bit counter:**
  - bit_count_enable=0: bit_count clears to 0 next cycle.
  - bit_count_enable=1: bit_count increments on each cycle where bit_done=1.
  - bit_count saturates at DATA_WIDTH+1 (data + parity) and never wraps.
- **data_transmitted_finished_flag:** combinational, = bit_count_enable & (bit_count == DATA_WIDTH-1).
- **Sampler:**
  - A 3-bit sample register captures rx_s on the cycles where edge_count = mid-1, mid and mid+1, with edge_count_enable=1.
  - In the cycle with edge_count = mid+1, majority(s0, s1, rx_s) is registered into sampled_bit, and sample_valid=1 in the following cycle.
  - sample_valid is a registered strobe, high for exactly 1 cycle per bit, in the cycle where edge_count = mid+2.
- **Mid-bit enable drop:** if edge_count_enable falls before edge mid+1, the partial samples are discarded. No sample_valid is produced and sampled_bit holds its value.
- **Simultaneous events:**
  - bit_done with bit_count_enable falling: no increment; the clear wins.
  - rst overrides everything in the same cycle.

## Timing
- **Reset values:** edge_count 0, bit_count 0, sampled_bit 1, sample_valid 0, bit_done 0, data_transmitted_finished_flag 0, p_q 8, synchroniser flops 1.
- **RX_IN latency:** 2 cycles from an RX_IN transition to rx_s.
- **Bit period:** exactly p_q cycles; bit_done is high on the last cycle of each bit.
- **Recovered-bit latency:** sampled_bit is valid from edge mid+2 of the current bit until the next bit's mid+2. For prescale=8 this is edge 6; for prescale=16 it is edge 10.
- **Counter updates:** edge_count and bit_count are registered; both update on the clk edge ending the bit_done cycle (edge_count→0, bit_count→+1).
- **Reset mid-frame:** all state returns to reset values on the next edge. The first bit after reset needs edge_count_enable re-asserted.

## Test plan
1. **Reset:** hold rst=1 for 2 cycles with RX_IN toggling → every output at its reset value; rst released with enables low → outputs stay at reset values.
2. **prescale=8, constant-0 line:** edge_count_enable=1, RX_IN=0 → edge_count counts 0..7 and repeats; bit_done high at edge 7 every 8 cycles; sample_valid at edge 6 with sampled_bit=0.
3. **Glitch rejection:** prescale=8; rx_s equals 1,0,1 at edges 3,4,5 → sampled_bit=1. Pattern 0,1,1 → 1. Pattern 0,0,1 → 0.
4. **Full frame:** prescale=16, DATA_WIDTH=8, byte 0xA5 sent LSB-first, both enables high during data.
   - sampled_bit sequence is 1,0,1,0,0,1,0,1.
   - data_transmitted_finished_flag is high only while bit_count=7.
   - With enables kept high for 3 further bits, bit_count saturates at 9.
5. **Mid-bit abort:** prescale=16; drop edge_count_enable at edge 4 → edge_count=0 next cycle; no sample_valid; sampled_bit unchanged. Drop bit_count_enable in the same cycle as bit_done → bit_count=0, no increment.
6. **Prescale change:** prescale changed 8→32 while edge_count_enable=1 → bit period stays 8 cycles. After the enable goes low for ≥1 cycle and rises again → bit period is 32 and sample_valid occurs at edge 18.
